// File: rtl/pri_pkg.sv
// pri_pkg: shared types and helpers for the pri_arb request arbiter.
//   pri_state_t : arbiter state (IDLE = no grant held, GRANT = grant held)
//   pri_idx_w() : width of a grant index for n channels (at least 1 bit)
//   PRI_N_MAX   : largest supported channel count
package pri_pkg;

  localparam int PRI_N_MAX = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } pri_state_t;

  // Index width for n channels; never returns 0 so W-1:0 ranges stay legal.
  function automatic int pri_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pri_enc_comb.sv
// pri_enc_comb: combinational highest-index priority encoder.
// Ports:
//   req : N-bit request vector
//   any : at least one request bit is set
//   idx : index of the highest set bit (0 when any=0)
module pri_enc_comb
  import pri_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = pri_idx_w(N)
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [W-1:0] idx
);

  // Ascending scan: the last set bit seen is the highest index.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        any = 1'b1;
        idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/pri_arb.sv
// pri_arb: registered N-channel arbiter with valid/ack handshake.
// A grant, once issued, is held unchanged until the consumer acks it; a new
// winner is chosen only in IDLE or in the cycle a grant is acked.
// Default build: fixed priority, highest index wins.
// Build option: define PRI_ARB_RR_EN for round-robin priority, where the most
// recently accepted channel drops to lowest priority.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   req        : N-bit level-sensitive request vector
//   ack        : consumer accepts the held grant (ignored when no grant)
//   gnt_valid  : a grant is held
//   gnt_idx    : granted channel index (0 when no grant)
//   gnt_onehot : one-hot grant (0 when no grant)
//   enc_out    : legacy encoder view {gnt_valid, gnt_idx}
module pri_arb
  import pri_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = pri_idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic [W:0]   enc_out
);

  pri_state_t   state_q;
  logic         valid_q;
  logic [W-1:0] idx_q;
  logic [N-1:0] onehot_q;

  // Winner for the next load point.
  logic         win_any;
  logic [W-1:0] idx_d;
  logic [N-1:0] onehot_d;

  logic         accept;
  assign accept = (state_q == GRANT) && ack;

`ifdef PRI_ARB_RR_EN
  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_eff;
  logic [N-1:0] mask;
  logic [N-1:0] masked_req;
  logic         m_any;
  logic [W-1:0] m_idx;
  logic         f_any;
  logic [W-1:0] f_idx;

  // On an accept the pointer moves to the accepted channel at this same edge,
  // so the back-to-back winner must already be ranked against that channel.
  assign ptr_eff = accept ? idx_q : ptr_q;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi] = (W'(gi) < ptr_eff);
    end
  endgenerate

  assign masked_req = req & mask;

  pri_enc_comb #(.N(N)) u_enc_masked (
    .req (masked_req),
    .any (m_any),
    .idx (m_idx)
  );

  pri_enc_comb #(.N(N)) u_enc_full (
    .req (req),
    .any (f_any),
    .idx (f_idx)
  );

  // Channels below the pointer rank first; when none request, the unmasked
  // search covers the wrap-around part of the order (N-1 down to ptr).
  assign win_any = f_any;
  assign idx_d   = m_any ? m_idx : f_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= idx_q;
    end
  end
`else
  pri_enc_comb #(.N(N)) u_enc (
    .req (req),
    .any (win_any),
    .idx (idx_d)
  );
`endif

  assign onehot_d = {{(N-1){1'b0}}, 1'b1} << idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_any) begin
            state_q  <= GRANT;
            valid_q  <= 1'b1;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
          end
        end
        GRANT: begin
          if (ack) begin
            if (win_any) begin
              idx_q    <= idx_d;
              onehot_q <= onehot_d;
            end else begin
              state_q  <= IDLE;
              valid_q  <= 1'b0;
              idx_q    <= '0;
              onehot_q <= '0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          valid_q  <= 1'b0;
          idx_q    <= '0;
          onehot_q <= '0;
        end
      endcase
    end
  end

  assign gnt_valid  = valid_q;
  assign gnt_idx    = idx_q;
  assign gnt_onehot = onehot_q;
  assign enc_out    = {valid_q, idx_q};

endmodule

// File: tb/tb_pri_arb.sv
// tb_pri_arb: self-checking bench for pri_arb with N=4.
// A behavioural model (priority list walk) is compared with the DUT on every
// cycle; directed scenarios add literal expectations; a random phase follows.
module tb_pri_arb;

  localparam int N = 4;
`ifdef PRI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [3:0] gnt_onehot;
  logic [2:0] enc_out;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  pri_arb #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .enc_out    (enc_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_valid = 0;
  int m_idx   = 0;
  int m_ptr   = 0;

  // Walk the priority list ptr-1, ptr-2, ... (mod N); first requester wins.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      int ch;
      ch = (p + N - k) % N;
      if (r[ch]) return ch;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0;
      m_idx   = 0;
      m_ptr   = 0;
    end else if (m_valid == 0 || ack) begin
      if (m_valid != 0 && RR) m_ptr = m_idx;
      if (req != 4'b0000) begin
        m_valid = 1;
        m_idx   = pick(req, m_ptr);
      end else begin
        m_valid = 0;
        m_idx   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0] e_oh;
      logic [2:0] e_enc;
      e_oh  = (m_valid != 0) ? (4'b0001 << m_idx) : 4'b0000;
      e_enc = {m_valid[0], m_idx[1:0]};
      checks++;
      if (gnt_valid !== m_valid[0] || gnt_idx !== m_idx[1:0] ||
          gnt_onehot !== e_oh || enc_out !== e_enc) begin
        errors++;
        $display("FAIL model t=%0t: got v=%b idx=%0d oh=%b enc=%b, expected v=%b idx=%0d oh=%b enc=%b",
                 $time, gnt_valid, gnt_idx, gnt_onehot, enc_out,
                 m_valid[0], m_idx, e_oh, e_enc);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Called at a negedge: apply inputs, advance past the next rising edge.
  task automatic drive(input logic [3:0] r, input logic a, input logic s);
    req = r;
    ack = a;
    rst = s;
    @(negedge clk);
  endtask

  logic [2:0] sweep_exp [16] = '{3'd0, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd6,
                                 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};

  initial begin
    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b1;

    // Reset state
    chk("reset_enc", {29'd0, enc_out}, 32'd0);
    chk("reset_onehot", {28'd0, gnt_onehot}, 32'd0);

    // 1. Exhaustive sweep from IDLE with ack=1
    for (int r = 0; r < 16; r++) begin
      drive(4'b0000, 1'b0, 1'b1);
      drive(4'(r), 1'b1, 1'b0);
      chk($sformatf("sweep_req%0d_enc", r), {29'd0, enc_out}, {29'd0, sweep_exp[r]});
    end

    // 2. Sticky grant
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0100, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(4'b0000, 1'b0, 1'b0);
      chk($sformatf("sticky_c%0d_enc", k), {29'd0, enc_out}, 32'd6);
    end
    drive(4'b0000, 1'b1, 1'b0);
    chk("sticky_release_valid", {31'd0, gnt_valid}, 32'd0);

    // 3. Back-to-back with all channels requesting
    drive(4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 1'b1, 1'b0);
      chk($sformatf("b2b_c%0d_idx", k), {30'd0, gnt_idx}, RR ? 32'(3 - (k % 4)) : 32'd3);
      chk($sformatf("b2b_c%0d_valid", k), {31'd0, gnt_valid}, 32'd1);
    end

    // 4. No preemption
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(4'b1010, 1'b0, 1'b0);
      chk($sformatf("nopre_c%0d_idx", k), {30'd0, gnt_idx}, 32'd1);
    end
    drive(4'b1010, 1'b1, 1'b0);
    chk("nopre_after_ack_idx", {30'd0, gnt_idx}, 32'd3);

    // 5. Reset mid-grant
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b1000, 1'b0, 1'b0);
    chk("rstmid_pre_enc", {29'd0, enc_out}, 32'd7);
    drive(4'b1111, 1'b0, 1'b1);
    chk("rstmid_enc", {29'd0, enc_out}, 32'd0);
    chk("rstmid_onehot", {28'd0, gnt_onehot}, 32'd0);
    drive(4'b1111, 1'b0, 1'b0);
    chk("rstmid_resume_enc", {29'd0, enc_out}, 32'd7);

    // 6. Spurious ack in IDLE; in RR mode ptr=3 must survive it
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b1000, 1'b0, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    chk("spur_idle_enc", {29'd0, enc_out}, 32'd0);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    chk("spur_still_idle_enc", {29'd0, enc_out}, 32'd0);
    drive(4'b1111, 1'b0, 1'b0);
    chk("spur_next_idx", {30'd0, gnt_idx}, RR ? 32'd2 : 32'd3);

    // Random phase, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      drive(4'($urandom), 1'($urandom), ($urandom_range(0, 63) == 0));
    end
    drive(4'b0000, 1'b0, 1'b0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
